// File: rtl/pe_onehot_pkg.sv
// pe_onehot_pkg: shared constants and helpers for the one-hot priority encoder.
//   PE_DEFAULT_WIDTH : default request vector width
//   idx_width(w)     : index width for a w-bit vector, $clog2(w) with a minimum of 1
//   onehot_to_idx(oh): OR-encoder from a one-hot vector (up to 64 bits) to a binary index
package pe_onehot_pkg;

    localparam int unsigned PE_DEFAULT_WIDTH = 8;

    function automatic int unsigned idx_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Each set bit ORs its own position into the result; for a one-hot input
    // this is the position of that bit, and an all-zero input yields 0.
    function automatic logic [5:0] onehot_to_idx(input logic [63:0] oh);
        logic [5:0] r;
        r = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (oh[i]) r = r | i[5:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_onehot_prefix_or_msb.sv
// prefix_or_msb: MSB-anchored prefix-OR, p[i] = |x[WIDTH-1:i], built as a
// Sklansky tree of depth ceil(log2 WIDTH).
//   x : input vector
//   p : prefix-OR from the MSB down to each bit
module prefix_or_msb
    import pe_onehot_pkg::*;
#(
    parameter int unsigned WIDTH = PE_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] p
);

    localparam int unsigned LEVELS = idx_width(WIDTH);

    // Work on the bit-reversed vector so the tree is a standard LSB-first
    // prefix: r[j] = x[WIDTH-1-j], q[j] = |r[j:0], p[i] = q[WIDTH-1-i].
    genvar l, j;
    for (l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [WIDTH-1:0] lv;
        if (l == 0) begin : g_leaf
            for (j = 0; j < WIDTH; j++) begin : g_rev
                assign lv[j] = x[WIDTH-1-j];
            end
        end else begin : g_node
            for (j = 0; j < WIDTH; j++) begin : g_bit
                // Upper half of each 2^l block picks up the last bit of the lower half.
                if (((j >> (l - 1)) & 1) == 1) begin : g_comb
                    assign lv[j] = g_lvl[l-1].lv[j] | g_lvl[l-1].lv[((j >> (l - 1)) << (l - 1)) - 1];
                end else begin : g_pass
                    assign lv[j] = g_lvl[l-1].lv[j];
                end
            end
        end
    end

    for (j = 0; j < WIDTH; j++) begin : g_out
        assign p[j] = g_lvl[LEVELS].lv[WIDTH-1-j];
    end

endmodule

// File: rtl/pe_onehot.sv
// pe_onehot: MSB-first priority encoder with one-hot result plus a registered,
// valid-qualified copy.
//   clk, rst_n  : clock, asynchronous active-low reset
//   a           : request vector, bit WIDTH-1 highest priority
//   in_valid    : qualifies a for the registered path
//   y, any      : combinational one-hot of highest set bit, OR-reduction of a
//   y_q, any_q  : registered y / any, captured when in_valid=1
//   out_valid   : registered in_valid
// Optional (macro PE_ONEHOT_IDX_EN):
//   idx, idx_q  : binary index of the set bit of y, and its registered copy
module pe_onehot
    import pe_onehot_pkg::*;
#(
    parameter int unsigned WIDTH = PE_DEFAULT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH-1:0]            a,
    input  logic                        in_valid,
    output logic [WIDTH-1:0]            y,
    output logic                        any,
    output logic [WIDTH-1:0]            y_q,
    output logic                        any_q,
`ifdef PE_ONEHOT_IDX_EN
    output logic [idx_width(WIDTH)-1:0] idx,
    output logic [idx_width(WIDTH)-1:0] idx_q,
`endif
    output logic                        out_valid
);

    logic [WIDTH-1:0] p;

    prefix_or_msb #(.WIDTH(WIDTH)) u_prefix (
        .x (a),
        .p (p)
    );

    // A bit survives only if nothing above it is set.
    assign y[WIDTH-1]   = a[WIDTH-1];
    assign y[WIDTH-2:0] = a[WIDTH-2:0] & ~p[WIDTH-1:1];
    assign any          = p[0];

`ifdef PE_ONEHOT_IDX_EN
    localparam int unsigned IW = idx_width(WIDTH);
    assign idx = IW'(onehot_to_idx(64'(y)));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            any_q     <= 1'b0;
            out_valid <= 1'b0;
`ifdef PE_ONEHOT_IDX_EN
            idx_q     <= '0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y_q   <= y;
                any_q <= any;
`ifdef PE_ONEHOT_IDX_EN
                idx_q <= idx;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pe_onehot.sv
module tb_pe_onehot;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic       in_valid;
    logic [7:0] y;
    logic       any;
    logic [7:0] y_q;
    logic       any_q;
    logic       out_valid;

    logic [4:0] a5;
    logic [4:0] y5;
    logic       any5;
    logic [4:0] y5_q;
    logic       any5_q;
    logic       out_valid5;

`ifdef PE_ONEHOT_IDX_EN
    logic [2:0] idx;
    logic [2:0] idx_q;
    logic [2:0] idx5;
    logic [2:0] idx5_q;
`endif

    int vectors    = 0;
    int miscompares = 0;

    pe_onehot #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .in_valid  (in_valid),
        .y         (y),
        .any       (any),
        .y_q       (y_q),
        .any_q     (any_q),
`ifdef PE_ONEHOT_IDX_EN
        .idx       (idx),
        .idx_q     (idx_q),
`endif
        .out_valid (out_valid)
    );

    pe_onehot #(.WIDTH(5)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a5),
        .in_valid  (in_valid),
        .y         (y5),
        .any       (any5),
        .y_q       (y5_q),
        .any_q     (any5_q),
`ifdef PE_ONEHOT_IDX_EN
        .idx       (idx5),
        .idx_q     (idx5_q),
`endif
        .out_valid (out_valid5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] exp_y;
        logic [7:0] below;
        logic [7:0] above;
        int unsigned k;

        rst_n    = 1'b0;
        a        = 8'h00;
        a5       = 5'h00;
        in_valid = 1'b0;
        #1;
        chk("reset_y_q", 64'(y_q), 64'h00);
        chk("reset_any_q", 64'(any_q), 64'h0);
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed combinational values
        a = 8'b0000_0000; #1;
        chk("zero_y", 64'(y), 64'h00);
        chk("zero_any", 64'(any), 64'h0);
        a = 8'b1111_1111; #1;
        chk("ones_y", 64'(y), 64'h80);
        chk("ones_any", 64'(any), 64'h1);
        a = 8'b0010_1101; #1;
        chk("2d_y", 64'(y), 64'h20);
        a = 8'b0000_0001; #1;
        chk("lsb_y", 64'(y), 64'h01);
        chk("lsb_any", 64'(any), 64'h1);

        // Random sweep across every priority position and a=0
        for (int n = 0; n < 256; n++) begin
            k = n % 9;
            r = 8'($urandom()) | 8'h80;
            a = r >> k;
            #1;
            exp_y = 8'h80 >> k;
            chk($sformatf("sweep_y_k%0d", k), 64'(y), 64'(exp_y));
            chk($sformatf("sweep_any_k%0d", k), 64'(any), 64'(k != 8));
        end

        // Exhaustive structural properties
        for (int v = 0; v < 256; v++) begin
            a = 8'(v);
            #1;
            chk($sformatf("onehot0_a%0h", v), 64'($onehot0(y)), 64'h1);
            chk($sformatf("subset_a%0h", v), 64'(y & a), 64'(y));
            below = (y << 1) - 8'd1;
            above = (y == 8'h00) ? 8'hFF : ~below;
            chk($sformatf("above_a%0h", v), 64'(a & above), 64'h00);
        end

`ifdef PE_ONEHOT_IDX_EN
        a = 8'b0100_0000; #1;
        chk("idx_6", 64'(idx), 64'd6);
        a = 8'b0000_0000; #1;
        chk("idx_zero", 64'(idx), 64'd0);
        a = 8'b0000_1011; #1;
        chk("idx_3", 64'(idx), 64'd3);
`endif

        // WIDTH=5 instance
        a5 = 5'b00110; #1;
        chk("w5_00110", 64'(y5), 64'h04);
        a5 = 5'b10000; #1;
        chk("w5_10000", 64'(y5), 64'h10);
        a5 = 5'b00000; #1;
        chk("w5_zero_any", 64'(any5), 64'h0);

        // Registered path
        @(negedge clk);
        a        = 8'b0001_0110;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("reg_y_q", 64'(y_q), 64'h10);
        chk("reg_any_q", 64'(any_q), 64'h1);
        chk("reg_out_valid", 64'(out_valid), 64'h1);
`ifdef PE_ONEHOT_IDX_EN
        chk("reg_idx_q", 64'(idx_q), 64'd4);
`endif
        a        = 8'hFF;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("hold_y_q", 64'(y_q), 64'h10);
        chk("hold_any_q", 64'(any_q), 64'h1);
        chk("hold_out_valid", 64'(out_valid), 64'h0);

        // Capture a pending value, then reset between edges
        @(negedge clk);
        a        = 8'b0000_0101;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_y_q", 64'(y_q), 64'h04);
        a = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_y_q", 64'(y_q), 64'h00);
        chk("async_any_q", 64'(any_q), 64'h0);
        chk("async_out_valid", 64'(out_valid), 64'h0);
`ifdef PE_ONEHOT_IDX_EN
        chk("async_idx_q", 64'(idx_q), 64'd0);
`endif
        a = 8'b0010_1101; #1;
        chk("rst_track_y", 64'(y), 64'h20);
        chk("rst_track_any", 64'(any), 64'h1);
        @(posedge clk); #1;
        chk("rst_hold_y_q", 64'(y_q), 64'h00);
        chk("rst_hold_out_valid", 64'(out_valid), 64'h0);

        // First capture after release
        @(negedge clk);
        rst_n    = 1'b1;
        a        = 8'b0000_0011;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_y_q", 64'(y_q), 64'h02);
        chk("post_rst_any_q", 64'(any_q), 64'h1);
        chk("post_rst_out_valid", 64'(out_valid), 64'h1);
`ifdef PE_ONEHOT_IDX_EN
        chk("post_rst_idx_q", 64'(idx_q), 64'd1);
`endif

        @(negedge clk);
        a = 8'h00;
        @(posedge clk); #1;
        chk("zero_y_q", 64'(y_q), 64'h00);
        chk("zero_any_q", 64'(any_q), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pe_onehot.md
Name: pe_onehot

Overview:
- MSB-first priority encoder with a one-hot result: `y` keeps only the highest set bit of `a`, and `y` is zero when `a` is zero.
- Built on a log-depth prefix-OR network (Sklansky), so the combinational path is O(log WIDTH).
- A registered copy of the result, qualified by a valid flag, is provided for pipelined consumers.
- Used as the priority stage ahead of arbiters and leading-one detectors.

Parameters:
- WIDTH, 8, input and output vector width; legal values 2 to 64.

Ports:
- clk  input  1  clock; all registers update on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  request vector; bit WIDTH-1 has the highest priority.
- in_valid  input  1  qualifies `a` for the registered path only.
- y  output  WIDTH  combinational one-hot of the highest set bit of `a`.
- any  output  1  combinational; equals the OR-reduction of `a`.
- y_q  output  WIDTH  registered `y`.
- any_q  output  1  registered `any`.
- out_valid  output  1  registered `in_valid`.

Behaviour:
- Combinational path, zero latency, independent of clk, rst_n and in_valid:
  - p[i] = OR of a[WIDTH-1:i].
  - y[WIDTH-1] = a[WIDTH-1].
  - y[i] = a[i] AND NOT p[i+1] for i < WIDTH-1.
- Combinational invariants:
  - `y` is either all zero or has exactly one bit set.
  - `y` is zero if and only if `a` is zero.
  - `any` = p[0].
- The prefix-OR must be a Sklansky-style network of depth ceil(log2 WIDTH), not a linear ripple chain.
- Registered path, 1-cycle latency:
  - On a rising clk edge with in_valid=1: y_q <= y, any_q <= any.
  - out_valid <= in_valid on every edge.
  - With in_valid=0, y_q and any_q hold their values, but out_valid falls to 0 on that edge.
- Reset:
  - While rst_n=0: y_q=0, any_q=0, out_valid=0, applied immediately (asynchronous).
  - Release is synchronous to clk; the first capture happens on the first rising edge after rst_n rises.
  - Reset asserted mid-stream discards the pending registered result.
  - The combinational outputs `y` and `any` are unaffected by reset.
- Boundary cases:
  - a=0 gives y=0, any=0.
  - a all ones gives only the MSB set in `y`.
  - a with only bit 0 set gives y=1.
- No X propagation when `a` is fully driven.

Optional Feature:
- Macro: PE_ONEHOT_IDX_EN.
- When defined, adds two outputs:
  - idx (width $clog2(WIDTH)): combinational binary index of the set bit in `y`, built as an OR-encoder of `y`; idx=0 when any=0.
  - idx_q: registered copy of idx, following the same capture and reset rules as y_q; resets to 0.
- When not defined, these ports and their logic are absent, and the rest of the behaviour is unchanged.

Decomposition:
- Package pe_onehot_pkg holds:
  - PE_DEFAULT_WIDTH = 8.
  - Function idx_width(w) returning $clog2(w), with a minimum of 1.
  - Function onehot_to_idx for use by the optional encoder.
- One sub-module: prefix_or_msb (parameter WIDTH; input x; output p, where p[i] = OR of x[WIDTH-1:i]), generate-based Sklansky tree.
- pe_onehot instantiates prefix_or_msb, then adds the AND-NOT stage and the output registers.

Test Plan:
- Random sweep of 256 vectors:
  - Stimulus: random byte with bit 7 forced to 1, then logically right-shifted by k = 0..8.
  - Required: y = 8'b1000_0000 >> k; any = (k != 8).
  - Covers all priority positions plus a=0.
- Directed combinational values:
  - a=8'b0000_0000 → y=8'b0000_0000, any=0.
  - a=8'b1111_1111 → y=8'b1000_0000.
  - a=8'b0010_1101 → y=8'b0010_0000.
  - a=8'b0000_0001 → y=8'b0000_0001.
- Registered path:
  - Drive a=8'b0001_0110 with in_valid=1 for one edge → next cycle y_q=8'b0001_0000, any_q=1, out_valid=1.
  - Then drive a=8'hFF with in_valid=0 → y_q stays 8'b0001_0000, out_valid=0.
- Asynchronous reset:
  - With y_q non-zero, pull rst_n low between edges → y_q=0, any_q=0 and out_valid=0 immediately.
  - `y` continues to track `a` while rst_n is low.
- Exhaustive WIDTH=8 property check:
  - All 256 values of `a`: $onehot0(y), (y & a) == y, and no bits of `a` above the set bit of `y`.
  - With PE_ONEHOT_IDX_EN defined: idx equals the position of the set bit, e.g. a=8'b0100_0000 → idx=6.
- WIDTH=5 instance:
  - a=5'b00110 → y=5'b00100.
  - a=5'b10000 → y=5'b10000.
